// File: rtl/keypad_scan_ctrl.sv
// rtl/keypad_scan_ctrl.sv - 4x4 keypad column scanner with press and release debounce
// Rotates one-hot column strobes, freezes on a single-row hit and reports one key per press.
module keypad_scan_ctrl #(
  parameter int SETTLE_CYCLES   = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int CNT_MAX = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       rows_meta_q, rows_meta_d;
  logic [3:0]       rows_s_q, rows_s_d;
  logic [3:0]       cols_q, cols_d;
  logic [3:0]       row_q, row_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;
  logic             row_hit;

  function automatic logic [1:0] oh_index(input logic [3:0] oh);
    return {oh[3] | oh[2], oh[3] | oh[1]};
  endfunction

  function automatic logic is_one_hot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Once a key is held only its own row line matters; other rows are ignored.
  assign row_hit = |(rows_s_q & row_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rows_meta_d = rows;
    rows_s_d    = rows_meta_q;
    cols_d      = cols_q;
    row_d       = row_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;

    case (state_q)
      ST_SCAN: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d = '0;
          if (is_one_hot(rows_s_q)) begin
            state_d = ST_DEBOUNCE;
            row_d   = rows_s_q;
          end else begin
            cols_d = {cols_q[2:0], cols_q[3]};
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_DEBOUNCE: begin
        if (rows_s_q != row_q) begin
          state_d = ST_SCAN;
          cnt_d   = '0;
          cols_d  = {cols_q[2:0], cols_q[3]};
        end else if (cnt_q == DEB_LAST) begin
          state_d     = ST_HELD;
          cnt_d       = '0;
          key_code_d  = {oh_index(row_q), oh_index(cols_q)};
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HELD: begin
        if (!row_hit) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
        end
      end
      ST_RELEASE: begin
        if (row_hit) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d    = ST_SCAN;
          cnt_d      = '0;
          cols_d     = {cols_q[2:0], cols_q[3]};
          key_held_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_SCAN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_SCAN;
      cnt_q       <= '0;
      rows_meta_q <= 4'd0;
      rows_s_q    <= 4'd0;
      cols_q      <= 4'b0001;
      row_q       <= 4'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rows_meta_q <= rows_meta_d;
      rows_s_q    <= rows_s_d;
      cols_q      <= cols_d;
      row_q       <= row_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign cols      = cols_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb/tb_keypad_scan_ctrl.sv - table-driven bench for keypad_scan_ctrl
// Vector i drives rows after posedge i and holds the outputs expected after posedge i.
module tb_keypad_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  keypad_scan_ctrl #(
    .SETTLE_CYCLES  (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rows     (rows),
    .cols     (cols),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] idx;
    logic [3:0] rows;
    logic [3:0] cols;
    logic       valid;
    logic       held;
    logic [3:0] code;
  } vec_t;

  vec_t  tbl[$];
  vec_t  exp_q[$];
  int    total = 0;
  int    bad = 0;
  string cur = "none";
  logic  started = 1'b0;
  logic  prev_valid = 1'b0;

  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] scan_from(input int i, input int a, input int c0);
    logic [3:0] one;
    one = 4'b0001;
    return one << ((c0 + (i - a) / 2) % 4);
  endfunction

  task automatic add(input logic [3:0] r, input logic [3:0] c, input logic v, input logic h,
                     input logic [3:0] k);
    vec_t e;
    e.idx   = 8'(tbl.size() + 1);
    e.rows  = r;
    e.cols  = c;
    e.valid = v;
    e.held  = h;
    e.code  = k;
    tbl.push_back(e);
  endtask

  task automatic fill(input int t);
    tbl.delete();
    case (t)
      0: for (int i = 1; i <= 20; i++)
           add(4'b0000, scan_from(i, 0, 0), 1'b0, 1'b0, 4'h0);
      1: for (int i = 1; i <= 14; i++)
           add((i >= 3) ? 4'b0100 : 4'b0000, (i >= 4) ? 4'b0100 : scan_from(i, 0, 0),
               i == 10, i >= 10, (i >= 10) ? 4'hA : 4'h0);
      2: for (int i = 1; i <= 13; i++)
           add((i >= 3 && i <= 6) ? 4'b0100 : 4'b0000,
               (i < 4) ? scan_from(i, 0, 0) : (i <= 9) ? 4'b0100 : scan_from(i, 10, 3),
               1'b0, 1'b0, 4'h0);
      3: for (int i = 1; i <= 16; i++)
           add((i == 7 || i == 8 || i == 10) ? 4'b0010 : 4'b0000,
               (i <= 9) ? scan_from(i, 0, 0) : (i <= 11) ? 4'b0001 : scan_from(i, 12, 1),
               1'b0, 1'b0, 4'h0);
      4: for (int i = 1; i <= 24; i++)
           add(((i >= 3 && i <= 10) || i == 13) ? 4'b0100 : 4'b0000,
               (i < 4) ? scan_from(i, 0, 0) : (i <= 20) ? 4'b0100 : scan_from(i, 21, 3),
               i == 10, i >= 10 && i <= 20, (i >= 10) ? 4'hA : 4'h0);
      5: for (int i = 1; i <= 24; i++)
           add(((i >= 3 && i <= 10) || i == 15) ? 4'b0100 : 4'b0000,
               (i < 4) ? scan_from(i, 0, 0) : (i <= 22) ? 4'b0100 : scan_from(i, 23, 3),
               i == 10, i >= 10 && i <= 22, (i >= 10) ? 4'hA : 4'h0);
      default: for (int i = 1; i <= 24; i++)
           add((i == 3 || i == 4) ? 4'b0011 : (i >= 5 && i <= 11) ? 4'b0010 :
               (i >= 12 && i <= 15) ? 4'b0110 : 4'b0000,
               (i < 6) ? scan_from(i, 0, 0) : (i <= 22) ? 4'b1000 : scan_from(i, 23, 0),
               i == 12, i >= 12 && i <= 22, (i >= 12) ? 4'h7 : 4'h0);
    endcase
  endtask

  task automatic do_reset(input string nm);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    rows  = 4'b0000;
    @(negedge clk);
    check({nm, ".cols"}, cols, 4'b0001);
    check({nm, ".code"}, key_code, 4'h0);
    check({nm, ".valid"}, {3'b000, key_valid}, 4'h0);
    check({nm, ".held"}, {3'b000, key_held}, 4'h0);
  endtask

  task automatic run_tbl(input int nlim);
    for (int i = 0; i < nlim && i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      rows = tbl[i].rows;
      exp_q.push_back(tbl[i]);
    end
    @(negedge clk);
    #1;
    check({cur, ".drained"}, 4'(exp_q.size()), 4'h0);
    exp_q.delete();
  endtask

  task automatic idle_quiet(input string nm, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rows = 4'b0000;
      @(negedge clk);
      check($sformatf("%s[%0d].valid", nm, i), {3'b000, key_valid}, 4'h0);
      check($sformatf("%s[%0d].held", nm, i), {3'b000, key_held}, 4'h0);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      vec_t e;
      e = exp_q.pop_front();
      check($sformatf("%s[%0d].cols", cur, e.idx), cols, e.cols);
      check($sformatf("%s[%0d].valid", cur, e.idx), {3'b000, key_valid}, {3'b000, e.valid});
      check($sformatf("%s[%0d].held", cur, e.idx), {3'b000, key_held}, {3'b000, e.held});
      check($sformatf("%s[%0d].code", cur, e.idx), key_code, e.code);
    end
    if (started) begin
      check("cols_one_hot", {3'b000, (cols != 4'd0) && ((cols & (cols - 4'd1)) == 4'd0)}, 4'h1);
      check("valid_single_pulse", {3'b000, key_valid & prev_valid}, 4'h0);
    end
    prev_valid = key_valid;
  end

  initial begin
    reset = 1'b1;
    rows  = 4'b0000;
    do_reset("reset0");
    started = 1'b1;
    for (int t = 0; t <= 6; t++) begin
      case (t)
        0: cur = "idle";
        1: cur = "clean_press";
        2: cur = "deb_last_abort";
        3: cur = "press_bounce";
        4: cur = "release_bounce";
        5: cur = "release_last_glitch";
        default: cur = "multi_key";
      endcase
      if (t != 0) do_reset({cur, ".rst"});
      fill(t);
      run_tbl(tbl.size());
    end

    cur = "rst_mid_held";
    do_reset("pre_held");
    fill(1);
    run_tbl(tbl.size());
    do_reset("rst_mid_held");
    idle_quiet("after_held_rst", 10);

    cur = "rst_mid_deb";
    do_reset("pre_deb");
    fill(1);
    run_tbl(8);
    do_reset("rst_mid_deb");
    idle_quiet("after_deb_rst", 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Scan controller for the 4x4 matrix keypad. Drives the one-hot column strobes in a cyclic rotation, samples the row inputs, and debounces both press and release. Reports exactly one key per press as a 4-bit code with a single-cycle valid pulse. Sits between the keypad pins and the display/digit-history logic, and replaces free-running column rotation with a sequenced scan that freezes on a candidate key.

## Interface
- SETTLE_CYCLES, 4: column dwell in cycles before rows are sampled; minimum 1
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required to accept a press or a release; minimum 1
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- rows  input  4  raw row lines, active-high pressed (`rows[i]` = row i), asynchronous to clk
- cols  output  4  one-hot column drive, active-high (`cols[j]` = column j)
- key_code  output  4  {row_idx[1:0], col_idx[1:0]} of the last accepted key
- key_valid  output  1  one-cycle pulse when a new key is accepted
- key_held  output  1  high while the accepted key is considered pressed

## Operation
- `rows` passes through a 2-flop synchronizer to `rows_s`. All decisions use `rows_s` only.
- One counter `cnt` is shared by all states. It is sized for max(SETTLE_CYCLES, DEBOUNCE_CYCLES) and clears on every state change.
- Column advance is a left rotate: 0001->0010->0100->1000->0001. `cols` is always exactly one-hot.
- **SCAN** (`cols` rotating):
  - `cnt` increments each cycle.
  - At `cnt == SETTLE_CYCLES-1`, sample `rows_s`:
    - Exactly one bit set: capture row index and current column index, go to DEBOUNCE, and hold `cols`.
    - Zero bits or two or more bits set: advance the column, clear `cnt`, stay in SCAN.
- **DEBOUNCE** (`cols` frozen):
  - Each cycle `rows_s` equals the captured one-hot row: `cnt` increments.
  - Any mismatch: go to SCAN and advance the column. No `key_valid`.
  - Match with `cnt == DEBOUNCE_CYCLES-1`: go to HELD, load `key_code`, assert `key_valid`.
- **HELD** (`cols` frozen, `key_held`=1):
  - Only the captured row bit is examined. Other row bits are ignored, so a second key is never reported.
  - Captured bit low: go to RELEASE.
- **RELEASE** (`cols` frozen, `key_held`=1):
  - `cnt` increments while the captured bit is low.
  - Captured bit high: return to HELD.
  - Bit low with `cnt == DEBOUNCE_CYCLES-1`: go to SCAN, advance the column, drop `key_held`.
- `key_code` holds its value until the next accepted key. It is not cleared on release.

## Timing
- Reset values, effective the cycle after `reset` is sampled high:
  - `cols`=0001, state SCAN, `cnt`=0, `key_code`=0, `key_valid`=0, `key_held`=0, synchronizer flops 0.
- Reset is honoured in every state, including mid-DEBOUNCE, HELD and RELEASE. It overrides every other transition.
- All outputs are registered.
- Column dwell in SCAN is SETTLE_CYCLES cycles.
- Full scan period with no key is 4*SETTLE_CYCLES cycles.
- `rows` to `rows_s` latency: 2 cycles.
- Suppose DEBOUNCE is entered at cycle T with rows stable. Then:
  - `key_valid`=1 at cycle T+DEBOUNCE_CYCLES and is low the following cycle.
  - `key_held` rises the same cycle as `key_valid`.
- Release: `key_held` falls, and `cols` advances, DEBOUNCE_CYCLES cycles after the captured `rows_s` bit goes and stays low.
- Boundary cases:
  - A mismatch on the final DEBOUNCE cycle aborts the press (no pulse).
  - A high glitch on the final RELEASE cycle returns to HELD.
  - `key_valid` never asserts twice for one press.

## Test plan
Run with SETTLE_CYCLES=2, DEBOUNCE_CYCLES=4.
- **Idle:** reset, then `rows`=0000 for 20 cycles -> `cols` steps 0001,0010,0100,1000,0001 every 2 cycles; `key_valid`, `key_held` stay 0.
- **Clean press:** `rows`=0100 held stable while `cols`=0100 -> `cols` freezes at 0100; exactly one `key_valid` with `key_code`=4'hA, 4 cycles after DEBOUNCE entry; `key_held`=1.
- **Press bounce:** `rows`=0010 on column 0, dropped to 0000 for 1 cycle during DEBOUNCE -> no `key_valid`; `cols` advances to 0010; scan resumes.
- **Release bounce:** from HELD, captured row low 2 cycles, high 1 cycle, then low 4+ cycles -> `key_held` stays 1 through the glitch, falls after 4 stable-low cycles; `cols` advances; `key_code` unchanged.
- **Multi-key:** `rows`=0011 on one column -> no DEBOUNCE entry and no pulse. Then a second row asserted during HELD on a key at row 1 col 3 (`key_code`=4'h7) -> no new `key_valid`; `key_code` stays 4'h7.
- **Reset mid-HELD:** assert `reset` for 1 cycle while `key_held`=1 -> next cycle `cols`=0001, `key_code`=0, `key_held`=0, `key_valid`=0.
